pwm_cfg_arbiter: RTL and testbench

Owns the five 8-bit PWM/output configuration registers (output enables 7:0 and 15:8, PWM enables 7:0 and 15:8, PWM duty cycle) and shares their write port between two requesters: port 0 (SPI transaction decoder, already synchronised to `clk`) and port 1 (on-chip sequencer or test host). It arbitrates requests and lets a requester lock ownership for multi-register bursts, with a timeout on the lock. It commits one write per transfer and flags illegal addresses. It sits between the SPI front end and the PWM/output stage, which reads its register outputs directly.

---
 rtl/pwm_cfg_arbiter.sv | 176 +++++++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cfg_arbiter
// Purpose  : Owns the five 8-bit PWM/output configuration registers and
//            shares their write port between two requesters. Port 0 is the
//            SPI transaction decoder and port 1 is the sequencer or test host.
//            Arbitration grants one owner at a time. An owner may lock the
//            grant for multi-register bursts, and an idle lock is released
//            after LOCK_TIMEOUT cycles. Writes to illegal addresses are
//            accepted without changing any register and pulse wr_err.
//
// Ports    : clk, rst                      clock, synchronous active-high reset
//            req{0,1}_valid/lock/addr/data write request and lock hold
//            req{0,1}_ready                transfer when valid & ready
//            en_reg_out_7_0 .. pwm_duty_cycle  registered config values
//            owner                         00 idle, 01 port 0, 10 port 1
//            wr_err                        1-cycle pulse, illegal address written
//            lock_timeout                  1-cycle pulse, lock force-released
//
// Config   : define PWM_CFG_ARB_ROUND_ROBIN_EN to break simultaneous requests
//            in favour of the port that was not granted last. When it is not
//            defined, port 0 always wins.
// Revision : 1.0  initial release
// ============================================================================
module pwm_cfg_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_lock,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_lock,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [1:0] owner,
  output logic       wr_err,
  output logic       lock_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(LOCK_TIMEOUT);
  localparam logic [6:0] LAST_ADDR   = 7'h04;

  // The state encoding is the owner code, so owner is read straight from state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic       grant1;       // arbitration result in IDLE: 1 selects port 1
  logic       own1;
  logic       cur_valid;
  logic       cur_lock;
  logic       xfer;
  logic [6:0] xfer_addr;
  logic [7:0] xfer_data;
  logic       timeout_nxt;

`ifdef PWM_CFG_ARB_ROUND_ROBIN_EN
  logic last_grant;         // 0: port 0 was granted last, 1: port 1

  // On a tie the port that was not granted last wins. A single request
  // always wins.
  always_comb grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if ((state == IDLE) && (req0_valid || req1_valid)) begin
      last_grant <= grant1;
    end
  end
`else
  always_comb grant1 = req1_valid & ~req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idle_cnt <= 8'h00;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    xfer         = 1'b0;
    own1         = (state == OWN1);
    cur_valid    = own1 ? req1_valid : req0_valid;
    cur_lock     = own1 ? req1_lock  : req0_lock;
    xfer_addr    = own1 ? req1_addr  : req0_addr;
    xfer_data    = own1 ? req1_data  : req0_data;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_nxt = 8'h00;
        if (req0_valid || req1_valid) begin
          state_nxt = grant1 ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        // Ready follows only the owner's own valid. The other port is held off.
        req0_ready = ~own1 & req0_valid;
        req1_ready =  own1 & req1_valid;
        if (cur_valid) begin
          xfer = 1'b1;
          if (cur_lock) begin
            idle_cnt_nxt = 8'h00;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!cur_lock) begin
          state_nxt = IDLE;
        end else if ((idle_cnt + 8'd1) == TIMEOUT_CNT) begin
          // The last OWN cycle is the LOCK_TIMEOUT-th idle cycle after the
          // last transfer. The pulse is then seen in the following IDLE cycle.
          state_nxt    = IDLE;
          idle_cnt_nxt = 8'h00;
          timeout_nxt  = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        idle_cnt_nxt = 8'h00;
      end
    endcase
  end

  assign owner = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_err          <= 1'b0;
      lock_timeout    <= 1'b0;
    end else begin
      wr_err       <= xfer && (xfer_addr > LAST_ADDR);
      lock_timeout <= timeout_nxt;
      if (xfer) begin
        case (xfer_addr)
          7'h00:   en_reg_out_7_0  <= xfer_data;
          7'h01:   en_reg_out_15_8 <= xfer_data;
          7'h02:   en_reg_pwm_7_0  <= xfer_data;
          7'h03:   en_reg_pwm_15_8 <= xfer_data;
          7'h04:   pwm_duty_cycle  <= xfer_data;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cfg_arbiter
// Purpose  : Self-checking bench for pwm_cfg_arbiter. Directed scenarios and
//            a randomized phase drive both ports. A cycle-level reference
//            model of the arbitration and register rules predicts every
//            output.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_cfg_arbiter;

  localparam int LT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_lock, req0_ready;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req1_valid, req1_lock, req1_ready;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [1:0] owner;
  logic       wr_err, lock_timeout;

  pwm_cfg_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_lock       (req0_lock),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_lock       (req1_lock),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .owner           (owner),
    .wr_err          (wr_err),
    .lock_timeout    (lock_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: a pending request is held until it has transferred.
  bit         pend [2];
  bit         lk   [2];
  logic [6:0] ad   [2];
  logic [7:0] dt   [2];

  // Reference model state.
  int         m_own;      // 0 idle, 1 port 0, 2 port 1
  int         m_idle;     // idle cycles while locked
  bit         m_last;     // 1 when port 1 was granted last
  logic [7:0] m_cfg [5];
  bit         m_err, m_to;
  int         n_timeouts = 0;
  int         n_errs = 0;

  task automatic apply_inputs();
    req0_valid = pend[0]; req0_lock = lk[0]; req0_addr = ad[0]; req0_data = dt[0];
    req1_valid = pend[1]; req1_lock = lk[1]; req1_addr = ad[1]; req1_data = dt[1];
  endtask

  task automatic check_outputs();
    check_eq("owner",  32'(owner), 32'(m_own));
    check_eq("ready0", 32'(req0_ready), 32'((m_own == 1) && pend[0]));
    check_eq("ready1", 32'(req1_ready), 32'((m_own == 2) && pend[1]));
    check_eq("out_7_0",  32'(en_reg_out_7_0),  32'(m_cfg[0]));
    check_eq("out_15_8", 32'(en_reg_out_15_8), 32'(m_cfg[1]));
    check_eq("pwm_7_0",  32'(en_reg_pwm_7_0),  32'(m_cfg[2]));
    check_eq("pwm_15_8", 32'(en_reg_pwm_15_8), 32'(m_cfg[3]));
    check_eq("duty",     32'(pwm_duty_cycle),  32'(m_cfg[4]));
    check_eq("wr_err",   32'(wr_err),       32'(m_err));
    check_eq("lock_to",  32'(lock_timeout), 32'(m_to));
  endtask

  // Advance the model by one clock given the current request inputs.
  task automatic model_step(input bit r, output bit x0, output bit x1);
    int p;
    x0 = !r && (m_own == 1) && pend[0];
    x1 = !r && (m_own == 2) && pend[1];
    m_err = 1'b0;
    m_to  = 1'b0;
    if (r) begin
      m_own = 0; m_idle = 0; m_last = 1'b0;
      for (int i = 0; i < 5; i++) m_cfg[i] = 8'h00;
    end else if (m_own == 0) begin
      if (pend[0] || pend[1]) begin
`ifdef PWM_CFG_ARB_ROUND_ROBIN_EN
        if (pend[0] && pend[1]) p = m_last ? 0 : 1;
        else                    p = pend[0] ? 0 : 1;
        m_last = (p == 1);
`else
        p = pend[0] ? 0 : 1;
`endif
        m_own  = p + 1;
        m_idle = 0;
      end
    end else begin
      p = m_own - 1;
      if (pend[p]) begin
        if (ad[p] < 7'd5) m_cfg[ad[p]] = dt[p];
        else begin m_err = 1'b1; n_errs++; end
        if (lk[p]) m_idle = 0;
        else       m_own  = 0;
      end else if (!lk[p]) begin
        m_own = 0;
      end else begin
        m_idle++;
        if (m_idle == LT) begin
          m_own = 0; m_to = 1'b1; m_idle = 0; n_timeouts++;
        end
      end
    end
  endtask

  // One clock: check current outputs, predict, clock, retire transfers.
  task automatic step(input bit r);
    bit x0, x1;
    rst = r;
    apply_inputs();
    #1;
    check_outputs();
    model_step(r, x0, x1);
    @(posedge clk);
    #1;
    if (x0) pend[0] = 1'b0;
    if (x1) pend[1] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((pend[0] || pend[1]) && guard < 40) begin
      step(1'b0);
      guard++;
    end
    check_eq(tag, 32'(pend[0] || pend[1]), 32'd0);
  endtask

  task automatic go_idle();
    lk[0] = 1'b0; lk[1] = 1'b0;
    step(1'b0); step(1'b0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; lk[p] = 1'b0; ad[p] = '0; dt[p] = '0;
    end
    m_own = 0; m_idle = 0; m_last = 1'b0; m_err = 1'b0; m_to = 1'b0;
    for (int i = 0; i < 5; i++) m_cfg[i] = 8'h00;
    rst = 1'b1;
    apply_inputs();
    @(posedge clk); #1;
    step(1'b1);

    // Single write: port 0 sets the duty cycle.
    pend[0] = 1'b1; ad[0] = 7'h04; dt[0] = 8'h80;
    drain("duty_write_bound");
    step(1'b0);

    // Simultaneous requests from both ports, repeated twice.
    for (int k = 0; k < 2; k++) begin
      pend[0] = 1'b1; ad[0] = 7'h00; dt[0] = 8'hAA;
      pend[1] = 1'b1; ad[1] = 7'h01; dt[1] = 8'h55;
      drain("tie_bound");
      step(1'b0);
    end

    // Port 1 locked burst over all registers while port 0 waits.
    pend[1] = 1'b1; lk[1] = 1'b1; ad[1] = 7'h00; dt[1] = 8'h10;
    step(1'b0);
    pend[0] = 1'b1; ad[0] = 7'h02; dt[0] = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      int guard = 0;
      if (i > 0) begin
        pend[1] = 1'b1; ad[1] = 7'(i); dt[1] = 8'(8'h10 + i); lk[1] = (i < 4);
      end
      while (pend[1] && guard < 10) begin step(1'b0); guard++; end
      check_eq("burst_bound", 32'(pend[1]), 32'd0);
    end
    drain("burst_drain_bound");

    // Illegal address.
    pend[0] = 1'b1; ad[0] = 7'h05; dt[0] = 8'hFF;
    drain("illegal_bound");
    step(1'b0); step(1'b0);

    // Lock timeout with port 0 pending behind the locked port 1.
    pend[1] = 1'b1; lk[1] = 1'b1; ad[1] = 7'h03; dt[1] = 8'h3C;
    step(1'b0); step(1'b0);
    pend[0] = 1'b1; ad[0] = 7'h01; dt[0] = 8'h99;
    for (int i = 0; i < LT + 4; i++) step(1'b0);
    check_eq("timeout_seen", 32'(n_timeouts > 0), 32'd1);
    go_idle();

    // Reset in the middle of a locked port 0 burst.
    pend[0] = 1'b1; lk[0] = 1'b1; ad[0] = 7'h02; dt[0] = 8'h5A;
    drain("pre_reset_bound");
    pend[0] = 1'b1; ad[0] = 7'h03; dt[0] = 8'hA5;
    step(1'b0);
    step(1'b1);
    pend[0] = 1'b0; lk[0] = 1'b0;
    step(1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 7) == 0) lk[p] = ~lk[p];
          if ($urandom_range(0, 2) == 0) begin
            pend[p] = 1'b1;
            ad[p] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(5, 127))
                                                : 7'($urandom_range(0, 4));
            dt[p] = 8'($urandom);
          end
        end
      end
      step($urandom_range(0, 249) == 0);
    end
    check_eq("rand_timeouts", 32'(n_timeouts > 1), 32'd1);
    check_eq("rand_errs", 32'(n_errs > 1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
